// File: rtl/lane_scheduler.sv
// lane_scheduler: rhythm-game lane scheduler.
//   One round is ROUND_LEN beats of TICK_DIV clocks each. Every beat lights one
//   target lane (chosen by an 8-bit LFSR); the player presses the matching key.
//   A clean press on the target lane scores a hit. Any other press, or no press,
//   is a miss. The round ends after ROUND_LEN beats or MISS_LIMIT misses.
// Ports:
//   CLOCK      system clock, rising edge
//   RESET      asynchronous active-high reset
//   START      level request to begin a round (sampled in IDLE/OVER)
//   KEY[3:0]   lane buttons, synchronous, active-high
//   HOLDIT     one-hot target lane, lit for the whole beat
//   GOTCHA     one-cycle one-hot hit pulse
//   SCORE      hit count, saturating at 255
//   MISSES     miss count
//   COMBO      consecutive-hit count (only with LANE_SCHEDULER_COMBO_EN)
//   PLAYING    high in ARM/BEAT/JUDGE
//   GAME_OVER  high in OVER
// Optional feature macro: LANE_SCHEDULER_COMBO_EN (adds COMBO and the
// double-score bonus for a hit when COMBO >= 4).
module lane_scheduler #(
   parameter int unsigned TICK_DIV   = 8,
   parameter int unsigned ROUND_LEN  = 16,
   parameter int unsigned MISS_LIMIT = 7
) (
   input  logic       CLOCK,
   input  logic       RESET,
   input  logic       START,
   input  logic [3:0] KEY,
   output logic [3:0] HOLDIT,
   output logic [3:0] GOTCHA,
   output logic [7:0] SCORE,
   output logic [2:0] MISSES,
`ifdef LANE_SCHEDULER_COMBO_EN
   output logic [7:0] COMBO,
`endif
   output logic       PLAYING,
   output logic       GAME_OVER
);

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      BEAT,
      JUDGE,
      OVER
   } state_t;

   state_t     state;
   state_t     state_nx;

   logic [7:0] lfsr;
   logic [3:0] key_q;
   logic [7:0] timer;
   logic [7:0] beats;
   logic [1:0] target;
   logic       resolved;
   logic       hit;
   logic [7:0] score;
   logic [2:0] misses;
   logic [3:0] gotcha;

   logic [3:0] target_oh;
   logic [3:0] key_edge;
   logic       press_now;
   logic       clean_hit;
   logic [2:0] misses_nx;
   logic [7:0] beats_nx;
   logic [7:0] score_nx;
   logic       round_end;
   logic       lfsr_fb;

   assign target_oh = 4'b0001 << target;
   assign key_edge  = KEY & ~key_q;
   // only the first edge of a beat is judged; later ones are ignored
   assign press_now = (state == BEAT) && !resolved && (key_edge != 4'b0000);
   // a hit needs the target lane and nothing else in the same cycle
   assign clean_hit = (key_edge == target_oh);
   assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

   assign misses_nx = hit ? misses : misses + 3'd1;
   assign beats_nx  = beats + 8'd1;
   assign round_end = (misses_nx == 3'(MISS_LIMIT)) || (beats_nx == 8'(ROUND_LEN));

`ifdef LANE_SCHEDULER_COMBO_EN
   logic [7:0] combo;
   logic [8:0] score_sum;

   assign score_sum = {1'b0, score} + ((combo >= 8'd4) ? 9'd2 : 9'd1);
   assign score_nx  = score_sum[8] ? 8'hFF : score_sum[7:0];
   assign COMBO     = combo;
`else
   assign score_nx  = (score == 8'hFF) ? score : score + 8'd1;
`endif

   // state register
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE, OVER: if (START) state_nx = ARM;
         ARM:        state_nx = BEAT;
         BEAT:       if (timer == 8'd0) state_nx = JUDGE;
         JUDGE:      state_nx = round_end ? OVER : ARM;
         default:    state_nx = IDLE;
      endcase
   end

   // state-decoded outputs
   always_comb begin
      HOLDIT    = 4'b0000;
      PLAYING   = 1'b0;
      GAME_OVER = 1'b0;
      case (state)
         ARM:     PLAYING = 1'b1;
         BEAT: begin
            PLAYING = 1'b1;
            HOLDIT  = target_oh;
         end
         JUDGE:   PLAYING = 1'b1;
         OVER:    GAME_OVER = 1'b1;
         default: ;
      endcase
   end

   // datapath
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         lfsr     <= 8'hA5;
         key_q    <= '0;
         timer    <= '0;
         beats    <= '0;
         target   <= '0;
         resolved <= 1'b0;
         hit      <= 1'b0;
         score    <= '0;
         misses   <= '0;
         gotcha   <= '0;
`ifdef LANE_SCHEDULER_COMBO_EN
         combo    <= '0;
`endif
      end else begin
         key_q  <= KEY;
         gotcha <= '0;
         case (state)
            IDLE, OVER: begin
               if (START) begin
                  score  <= '0;
                  misses <= '0;
                  beats  <= '0;
`ifdef LANE_SCHEDULER_COMBO_EN
                  combo  <= '0;
`endif
               end
            end
            ARM: begin
               target   <= lfsr[1:0];
               timer    <= 8'(TICK_DIV - 1);
               resolved <= 1'b0;
               hit      <= 1'b0;
            end
            BEAT: begin
               if (timer != 8'd0) timer <= timer - 8'd1;
               if (press_now) begin
                  resolved <= 1'b1;
                  hit      <= clean_hit;
                  if (clean_hit) gotcha <= target_oh;
               end
            end
            JUDGE: begin
               if (hit) begin
                  score <= score_nx;
`ifdef LANE_SCHEDULER_COMBO_EN
                  if (combo != 8'hFF) combo <= combo + 8'd1;
`endif
               end else begin
                  misses <= misses_nx;
`ifdef LANE_SCHEDULER_COMBO_EN
                  combo  <= '0;
`endif
               end
               beats <= beats_nx;
               lfsr  <= {lfsr[6:0], lfsr_fb};
            end
            default: ;
         endcase
      end
   end

   assign GOTCHA = gotcha;
   assign SCORE  = score;
   assign MISSES = misses;

endmodule

// File: tb/tb_lane_scheduler.sv
// tb_lane_scheduler: scoreboard bench for lane_scheduler.
//   Driver tasks issue directed key patterns per beat and push the expected
//   beat lane, hit pulse and post-judge counters into queues; an independent
//   monitor pops and compares whenever the DUT shows a beat, a GOTCHA pulse
//   or finishes a judgement. Build with LANE_SCHEDULER_COMBO_EN to cover COMBO.
module tb_lane_scheduler;

   localparam int unsigned TICK_DIV   = 8;
   localparam int unsigned ROUND_LEN  = 16;
   localparam int unsigned MISS_LIMIT = 7;

   logic       CLOCK = 1'b0;
   logic       RESET;
   logic       START;
   logic [3:0] KEY;
   logic [3:0] HOLDIT;
   logic [3:0] GOTCHA;
   logic [7:0] SCORE;
   logic [2:0] MISSES;
   logic       PLAYING;
   logic       GAME_OVER;
`ifdef LANE_SCHEDULER_COMBO_EN
   logic [7:0] COMBO;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [7:0] score;
      logic [2:0] misses;
      logic       over;
      logic [7:0] combo;
   } judge_t;

   logic [3:0] beat_q[$];
   logic [3:0] gotcha_q[$];
   judge_t     judge_q[$];

   // reference model state
   logic [7:0] m_lfsr;
   logic [7:0] m_score;
   logic [7:0] m_combo;
   logic [7:0] m_beats;
   logic [2:0] m_misses;
   logic       m_over;

   lane_scheduler #(
      .TICK_DIV  (TICK_DIV),
      .ROUND_LEN (ROUND_LEN),
      .MISS_LIMIT(MISS_LIMIT)
   ) dut (
      .CLOCK    (CLOCK),
      .RESET    (RESET),
      .START    (START),
      .KEY      (KEY),
      .HOLDIT   (HOLDIT),
      .GOTCHA   (GOTCHA),
      .SCORE    (SCORE),
      .MISSES   (MISSES),
`ifdef LANE_SCHEDULER_COMBO_EN
      .COMBO    (COMBO),
`endif
      .PLAYING  (PLAYING),
      .GAME_OVER(GAME_OVER)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name, input string msg);
      checks++;
      errors++;
      $display("FAIL %s: %s", name, msg);
   endtask

   function automatic logic [3:0] oh(input logic [1:0] t);
      return 4'b0001 << t;
   endfunction

   // 0 release, 1 target, 2 target + lane below, 3 lane above only, 4 all
   function automatic logic [3:0] kval(input int code, input logic [3:0] t);
      case (code)
         1:       return t;
         2:       return t | {t[0], t[3:1]};
         3:       return {t[2:0], t[3]};
         4:       return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   task automatic model_reset();
      m_lfsr   = 8'hA5;
      m_score  = '0;
      m_combo  = '0;
      m_beats  = '0;
      m_misses = '0;
      m_over   = 1'b0;
   endtask

   task automatic judge_model(input bit hit);
      int     inc;
      judge_t j;
      if (hit) begin
`ifdef LANE_SCHEDULER_COMBO_EN
         inc     = (m_combo >= 8'd4) ? 2 : 1;
         m_combo = (m_combo == 8'hFF) ? 8'hFF : m_combo + 8'd1;
`else
         inc     = 1;
`endif
         m_score = (int'(m_score) + inc > 255) ? 8'hFF : 8'(int'(m_score) + inc);
      end else begin
         m_misses = m_misses + 3'd1;
         m_combo  = '0;
      end
      m_beats = m_beats + 8'd1;
      m_lfsr  = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      m_over  = (m_misses == 3'(MISS_LIMIT)) || (m_beats == 8'(ROUND_LEN));
      j.score  = m_score;
      j.misses = m_misses;
      j.over   = m_over;
      j.combo  = m_combo;
      judge_q.push_back(j);
   endtask

   // returns at the falling edge of the first BEAT cycle
   task automatic wait_beat(output bit ok, output int n);
      ok = 1'b0;
      n  = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge CLOCK);
         n++;
         if (HOLDIT != 4'b0000) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail("beat_timeout", "no beat within 64 cycles");
   endtask

   task automatic start_round();
      @(negedge CLOCK);
      START = 1'b1;
      @(negedge CLOCK);
      START = 1'b0;
      chk("arm_playing", PLAYING, 1);
      chk("arm_holdit", HOLDIT, 0);
      chk("arm_score", SCORE, 0);
      chk("arm_misses", MISSES, 0);
      m_score  = '0;
      m_misses = '0;
      m_beats  = '0;
      m_combo  = '0;
      m_over   = 1'b0;
   endtask

   // one beat: set KEY from code k1 at beat cycle c1 and k2 at c2 (-1 = never)
   task automatic do_beat(input int c1, input int k1, input int c2, input int k2, input bit hit);
      logic [3:0] t;
      bit         ok;
      int         n;
      wait_beat(ok, n);
      if (!ok) return;
      t = oh(m_lfsr[1:0]);
      beat_q.push_back(t);
      if (hit) gotcha_q.push_back(t);
      for (int c = 0; c < int'(TICK_DIV); c++) begin
         if (c != 0) @(negedge CLOCK);
         if (c == c1) KEY = kval(k1, t);
         if (c == c2) KEY = kval(k2, t);
      end
      judge_model(hit);
   endtask

   // monitor / scoreboard
   initial begin : monitor
      int         run;
      int         glen;
      bit         pend;
      logic [3:0] hv;
      logic [3:0] e;
      judge_t     j;
      run  = 0;
      glen = 0;
      pend = 1'b0;
      hv   = '0;
      forever begin
         @(negedge CLOCK);
         if (RESET) begin
            run  = 0;
            glen = 0;
            pend = 1'b0;
         end else begin
            if (GOTCHA != 4'b0000) begin
               if (glen == 0) begin
                  if (gotcha_q.size() == 0) begin
                     fail("gotcha_unexpected", $sformatf("got %b expected no pulse", GOTCHA));
                  end else begin
                     e = gotcha_q.pop_front();
                     chk("gotcha", GOTCHA, e);
                  end
               end
               glen++;
            end else if (glen != 0) begin
               chk("gotcha_len", glen, 1);
               glen = 0;
            end

            if (HOLDIT != 4'b0000) begin
               if (run == 0) hv = HOLDIT;
               else if (HOLDIT !== hv) chk("holdit_stable", HOLDIT, hv);
               run++;
            end else if (run != 0) begin
               if (beat_q.size() == 0) begin
                  fail("beat_unexpected", $sformatf("got lane %b expected none", hv));
               end else begin
                  e = beat_q.pop_front();
                  chk("beat_lane", hv, e);
               end
               chk("beat_len", run, TICK_DIV);
               chk("judge_playing", PLAYING, 1);
               run  = 0;
               pend = 1'b1;
            end else if (pend) begin
               pend = 1'b0;
               if (judge_q.size() == 0) begin
                  fail("judge_unexpected", "judgement with no expectation queued");
               end else begin
                  j = judge_q.pop_front();
                  chk("score", SCORE, j.score);
                  chk("misses", MISSES, j.misses);
                  chk("game_over", GAME_OVER, j.over);
                  chk("playing", PLAYING, !j.over);
`ifdef LANE_SCHEDULER_COMBO_EN
                  chk("combo", COMBO, j.combo);
`endif
               end
            end
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      bit ok;
      int n;
      logic [3:0] t;
      RESET = 1'b0;
      START = 1'b0;
      KEY   = 4'b0000;
      model_reset();
      #2 RESET = 1'b1;
      #10;
      chk("rst_holdit", HOLDIT, 0);
      chk("rst_gotcha", GOTCHA, 0);
      chk("rst_score", SCORE, 0);
      chk("rst_misses", MISSES, 0);
      chk("rst_playing", PLAYING, 0);
      chk("rst_game_over", GAME_OVER, 0);
      @(negedge CLOCK);
      RESET = 1'b0;
      repeat (3) @(negedge CLOCK);
      chk("idle_waits_start", PLAYING, 0);

      // round 1: mixed hits and misses, ends on MISS_LIMIT
      start_round();
      do_beat(3, 1, 4, 0, 1);      // clean hit mid-beat
      do_beat(7, 1, -1, 0, 1);     // hit in the timer-0 cycle, key stays held
      do_beat(4, 2, -1, 0, 0);     // target + neighbour together
      do_beat(0, 1, 3, 3, 1);      // hit, later wrong press ignored
      do_beat(1, 3, 4, 1, 0);      // wrong first, later target ignored
      @(negedge CLOCK);
      KEY = 4'b1111;               // pressed during JUDGE, held into the beat
      do_beat(2, 0, -1, 0, 0);
      @(negedge CLOCK);
      @(negedge CLOCK);
      KEY = oh(m_lfsr[1:0]);       // target pressed during ARM
      do_beat(1, 0, -1, 0, 0);
      do_beat(-1, 0, -1, 0, 0);
      do_beat(-1, 0, -1, 0, 0);
      do_beat(-1, 0, -1, 0, 0);    // seventh miss

      repeat (3) @(negedge CLOCK);
      KEY = 4'b1111;
      repeat (2) @(negedge CLOCK);
      chk("over_score", SCORE, m_score);
      chk("over_misses", MISSES, m_misses);
      chk("over_game_over", GAME_OVER, 1);
      chk("over_playing", PLAYING, 0);
      chk("over_gotcha", GOTCHA, 0);
      chk("over_holdit", HOLDIT, 0);
      KEY = 4'b0000;

      // round 2: hit every beat, START held for a few beats mid-round
      start_round();
      for (int i = 0; i < int'(ROUND_LEN); i++) begin
         if (i == 3) START = 1'b1;
         if (i == 6) START = 1'b0;
         do_beat(i % 7, 1, (i % 7) + 1, 0, 1);
      end
      repeat (3) @(negedge CLOCK);
      chk("round2_over", GAME_OVER, 1);

      // round 3: one hit, then reset in the middle of the next beat
      start_round();
      do_beat(2, 1, 3, 0, 1);
      wait_beat(ok, n);
      @(negedge CLOCK);
      @(negedge CLOCK);
      t = oh(m_lfsr[1:0]);
      KEY = t;
      @(posedge CLOCK);
      #2;
      chk("pre_reset_gotcha", GOTCHA, t);
      chk("pre_reset_score", SCORE, m_score);
      RESET = 1'b1;
      #1;
      chk("midrst_holdit", HOLDIT, 0);
      chk("midrst_gotcha", GOTCHA, 0);
      chk("midrst_score", SCORE, 0);
      chk("midrst_misses", MISSES, 0);
      chk("midrst_playing", PLAYING, 0);
      chk("midrst_game_over", GAME_OVER, 0);
      @(negedge CLOCK);
      chk("midrst_hold_playing", PLAYING, 0);
      @(negedge CLOCK);
      RESET = 1'b0;
      KEY   = 4'b0000;
      model_reset();

      // first beat after reset must target lane 1 and last exactly one ARM cycle
      start_round();
      beat_q.push_back(4'b0010);
      wait_beat(ok, n);
      chk("arm_len", n, 1);
      chk("post_reset_lane", HOLDIT, 4'b0010);
      repeat (TICK_DIV - 1) @(negedge CLOCK);
      judge_model(1'b0);

      repeat (4) @(negedge CLOCK);
      chk("beat_q_drained", beat_q.size(), 0);
      chk("gotcha_q_drained", gotcha_q.size(), 0);
      chk("judge_q_drained", judge_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
